// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: aligns loads/stores onto an 8-byte bus.
// Four-state handshake: IDLE -> REQ -> WAIT -> DONE -> IDLE.
module mem_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memRead_in,
  input  logic            memWrite_in,
  input  logic [2:0]      memType_in,
  input  logic [XLEN-1:0] ALUResult_in,
  input  logic [XLEN-1:0] writeData_in,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic [XLEN-1:0] loadData_out,
  output logic            stall_out,
  output logic            misaligned_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic            op;
  logic            mis;
  logic            capture;
  logic [2:0]      mtype;
  logic [2:0]      off;
  logic [7:0]      mask;

  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wstrb_q;
  logic [2:0]      type_q;
  logic [2:0]      off_q;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] load_nx;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

  assign op    = memRead_in | memWrite_in;
  assign mtype = (memType_in == 3'b111) ? 3'b011 : memType_in;
  assign off   = ALUResult_in[2:0];

  always_comb begin
    mask = 8'h01;
    mis  = 1'b0;
    unique case (mtype[1:0])
      2'd0: begin
        mask = 8'h01;
        mis  = 1'b0;
      end
      2'd1: begin
        mask = 8'h03;
        mis  = off[0];
      end
      2'd2: begin
        mask = 8'h0F;
        mis  = |off[1:0];
      end
      default: begin
        mask = 8'hFF;
        mis  = |off;
      end
    endcase
  end

  // Response data is always the whole aligned doubleword.
  assign shifted = dmem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    unique case (type_q)
      3'b000:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_nx       = state;
    stall_out      = 1'b0;
    misaligned_out = 1'b0;
    dmem_req_valid = 1'b0;
    capture        = 1'b0;
    load_nx        = load_q;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (mis) begin
            misaligned_out = 1'b1;
          end else begin
            stall_out = 1'b1;
            capture   = 1'b1;
            state_nx  = REQ;
          end
        end
      end
      REQ: begin
        stall_out      = 1'b1;
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        stall_out = 1'b1;
        if (dmem_rsp_valid) begin
          state_nx = DONE;
          if (!we_q) load_nx = ext;
        end
      end
      DONE: begin
        // Same instruction still sits on the inputs; never reissue it.
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      type_q  <= '0;
      off_q   <= '0;
      load_q  <= '0;
    end else begin
      state  <= state_nx;
      load_q <= load_nx;
      if (capture) begin
        we_q    <= memWrite_in;
        addr_q  <= {ALUResult_in[XLEN-1:3], 3'b000};
        wdata_q <= memWrite_in ? (writeData_in << {off, 3'b000}) : '0;
        wstrb_q <= mask << off;
        type_q  <= mtype;
        off_q   <= off;
      end
    end
  end

  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wstrb = wstrb_q;
  assign loadData_out   = load_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: XLEN, 64, data/address width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- memRead_in  in  1  load in MEM stage.
- memWrite_in  in  1  store in MEM stage.
- memType_in  in  3  access type (REQ-008).
- ALUResult_in  in  XLEN  byte address.
- writeData_in  in  XLEN  store data, LSB-justified.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = write.
- dmem_req_addr  out  XLEN  address with bits [2:0] = 0.
- dmem_req_wdata  out  XLEN  lane-positioned store data.
- dmem_req_wstrb  out  8  byte enables.
- dmem_rsp_valid  in  1  response or write acknowledge.
- dmem_rsp_rdata  in  XLEN  aligned 8-byte read data.
- loadData_out  out  XLEN  extended load result.
- stall_out  out  1  freeze IF/ID/EX and the EX/MEM register.
- misaligned_out  out  1  misaligned access flag.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-004 IDLE: when op = memRead_in|memWrite_in is present and aligned, SHALL:
- assert stall_out combinationally;
- register the address, we, wdata and wstrb;
- go to REQ.
REQ-005 When memRead_in and memWrite_in are both 1, the op SHALL be treated as a store.
REQ-006 REQ: SHALL drive dmem_req_valid=1 from the registers, which stay stable until accepted. When dmem_req_valid && dmem_req_ready, SHALL go to WAIT.
REQ-007 WAIT: on dmem_rsp_valid, SHALL:
- capture the extended load data (loads only);
- go to DONE.
dmem_rsp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-008 memType encoding:
- 000 LB, 001 LH, 010 LW, 011 LD/SD;
- 100 LBU, 101 LHU, 110 LWU;
- stores use 000/001/010/011 for SB/SH/SW/SD;
- 111 SHALL be treated as 011.
REQ-009 Alignment: size 1/2/4/8 bytes; an access is misaligned when the address low bits are non-zero modulo the size.
REQ-010 Misaligned op in IDLE:
- misaligned_out=1 combinationally while the op is present;
- no request issued;
- stall_out=0;
- state stays IDLE.
REQ-011 Store lanes:
- off = addr[2:0];
- wstrb = ((1<<size)-1)<<off;
- wdata = writeData_in<<(8*off).
REQ-012 Load extraction: SHALL take (rdata>>(8*off)) truncated to size, then sign-extend (000/001/010) or zero-extend (100/101/110) to XLEN.
REQ-013 stall_out SHALL be 1 in REQ and WAIT, and 0 in DONE.
REQ-014 DONE: SHALL last exactly one cycle. It SHALL ignore all inputs, because the same instruction is still presented and must not be reissued. It SHALL then go to IDLE.
REQ-015 loadData_out SHALL hold its registered value until the next load completes. Stores and misaligned ops SHALL leave it unchanged.
REQ-016 Timing with ready=1 at REQ entry and response one cycle after acceptance: stall_out high for exactly 3 cycles (IDLE, REQ, WAIT), loadData_out valid in DONE. Each ready-low cycle or response-delay cycle SHALL add one stall cycle.
REQ-017 dmem_req_valid SHALL never be asserted in IDLE, WAIT or DONE.

Reset
REQ-018 Reset SHALL asynchronously force:
- state=IDLE;
- dmem_req_valid=0;
- request registers and loadData_out = 0.
REQ-019 Reset mid-transaction (REQ or WAIT) SHALL abandon the access; a later dmem_rsp_valid SHALL be ignored.
REQ-020 After reset deassertion the block SHALL accept a new op on the next rising edge.

Verification
REQ-021 LD, addr 0x1000, ready=1, rdata=0x8877665544332211 one cycle after accept -> loadData_out=0x8877665544332211 in DONE; stall high 3 cycles.
REQ-022 LB, addr 0x1003, rdata byte3=0x80 -> loadData_out=0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x0000000000000080.
REQ-023 SH, addr 0x2006, writeData=0xABCD -> req_addr=0x2000, wstrb=0xC0, wdata[63:48]=0xABCD, we=1.
REQ-024 LW, addr 0x1002 -> misaligned_out=1, no dmem_req_valid, stall_out=0.
REQ-025 LD with ready low for 4 cycles -> request fields stable throughout, stall extended by 4 cycles.
REQ-026 Reset asserted in WAIT, then rsp_valid -> state IDLE, loadData_out=0, no DONE cycle.
